// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider: unsigned DW-bit dividend / VW-bit divisor.
// One quotient bit per clock, start/done handshake, divide-by-zero flag.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, sampled only while idle
//   a     : dividend, captured on the accepting edge
//   b     : divisor, captured on the accepting edge
//   q     : quotient, held from done until the next done
//   r     : remainder, held from done until the next done
//   busy  : high while the restoring steps run
//   done  : one-cycle result-valid pulse
//   dz    : divide-by-zero flag, updated with done
module seq_divider_8by4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          dz
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e        state_q;
  logic [DW-1:0] dvd_q;
  logic [DW-1:0] dvd_d;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] rem_q;
  logic [VW-1:0] rem_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] r_q;
  logic          busy_q;
  logic          done_q;
  logic          dz_q;

  // Working remainder is VW+1 bits after the shift.
  logic [VW:0]   rem_sh;
  logic [VW:0]   rem_sub;
  logic          fit;

  // The stored remainder is always below the divisor, so it needs
  // only VW bits; the shifted value gets the extra bit so the
  // compare cannot overflow.
  // When rem_sh >= divisor the difference is below the divisor, so
  // bit VW is clear; otherwise the wrapped difference sets it.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DW-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    fit     = ~rem_sub[VW];
    rem_d   = fit ? rem_sub[VW-1:0] : rem_sh[VW-1:0];
    // Quotient bits enter at the LSB as dividend bits leave the MSB.
    dvd_d   = {dvd_q[DW-2:0], fit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (b != '0) begin
              dvd_q   <= a;
              dvs_q   <= b;
              rem_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              q_q     <= '1;
              r_q     <= '0;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            q_q     <= dvd_d;
            r_q     <= rem_d;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Bench for seq_divider_8by4: timeline/arithmetic model plus
// directed literal checks and randomized traffic.
module tb_seq_divider_8by4;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int ONES = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [VW-1:0] b = '0;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          busy;
  logic          done;
  logic          dz;

  seq_divider_8by4 #(.DW(DW), .VW(VW)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining step count + arithmetic results.
  int m_calc = 0;
  int a_cap = 0;
  int b_cap = 0;
  int exp_q = 0;
  int exp_r = 0;
  int exp_dz = 0;
  int exp_busy = 0;
  int exp_done = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_calc = 0;
      exp_q = 0;
      exp_r = 0;
      exp_dz = 0;
      exp_busy = 0;
      exp_done = 0;
    end else if (exp_done != 0) begin
      exp_done = 0;
    end else if (m_calc > 0) begin
      m_calc--;
      if (m_calc == 0) begin
        exp_busy = 0;
        exp_done = 1;
        exp_q = a_cap / b_cap;
        exp_r = a_cap % b_cap;
        exp_dz = 0;
      end
    end else if (start) begin
      a_cap = int'(a);
      b_cap = int'(b);
      if (b_cap == 0) begin
        exp_done = 1;
        exp_q = ONES;
        exp_r = 0;
        exp_dz = 1;
      end else begin
        m_calc = DW;
        exp_busy = 1;
      end
    end
  end

  bit chk_en = 0;
  bit sweep = 0;
  int last_done = -1;
  int sweep_dones = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", int'(done), exp_done);
      chk("busy", int'(busy), exp_busy);
      chk("q", int'(q), exp_q);
      chk("r", int'(r), exp_r);
      chk("dz", int'(dz), exp_dz);
      if (sweep && done) begin
        if (last_done >= 0) chk("spacing", cyc - last_done, DW + 2);
        last_done = cyc;
        sweep_dones++;
      end
    end
  end

  // One operation with literal expectations; rp re-pulses start
  // with a=1,b=1 during CALC.
  task automatic op(input int av, input int bv, input int eq,
                    input int er, input int edz, input int ebusy,
                    input bit rp);
    int nb;
    bit got;
    @(negedge clk);
    a = DW'(av);
    b = VW'(bv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done) got = 1;
      else begin
        if (busy) nb++;
        if (rp && (k == 2 || k == 4)) begin
          start = 1'b1;
          a = 1;
          b = 1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_seen", int'(got), 1);
    chk("lit_q", int'(q), eq);
    chk("lit_r", int'(r), er);
    chk("lit_dz", int'(dz), edz);
    if (ebusy >= 0) chk("busy_len", nb, ebusy);
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dz", int'(dz), 0);

    // T1..T4
    op(200, 13, 15, 5, 0, 8, 0);
    op(255, 1, 255, 0, 0, 8, 0);
    op(0, 15, 0, 0, 0, -1, 0);
    op(7, 9, 0, 7, 0, -1, 0);
    op(100, 0, 255, 0, 1, 0, 0);
    op(100, 10, 10, 0, 0, -1, 0);
    op(143, 11, 13, 0, 0, 8, 1);

    // T5: reset mid-calculation
    @(negedge clk);
    a = 143;
    b = 11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_q", int'(q), 0);
    chk("t5_r", int'(r), 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t5_no_done", nd, 0);
    op(9, 2, 4, 1, 0, 8, 0);

    // T6: exhaustive sweep, start held high
    repeat (3) @(negedge clk);
    sweep = 1;
    last_done = -1;
    start = 1'b1;
    for (int av = 0; av < 256; av++) begin
      for (int bv = 1; bv < 16; bv++) begin
        a = DW'(av);
        b = VW'(bv);
        repeat (DW + 2) @(negedge clk);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    sweep = 0;
    chk("sweep_dones", sweep_dones, 256 * 15);

    // Randomized traffic, including stray starts and resets
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = DW'($urandom);
      b = VW'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
